// File: rtl/zpu_mem_arbiter.sv
// zpu_mem_arbiter: round-robin two-master arbiter onto one strobe/busy memory slave.
// Define ZPU_MEM_ARBITER_TIMEOUT_EN to build the slave-busy watchdog.
module zpu_mem_arbiter #(
   parameter int ADDR_W         = 28,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_re,
   input  logic              m0_we,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [3:0]        m0_mask,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_busy,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m1_re,
   input  logic              m1_we,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [3:0]        m1_mask,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_busy,
   output logic [ADDR_W-1:0] s_addr,
   output logic              s_re,
   output logic              s_we,
   output logic [DATA_W-1:0] s_wdata,
   output logic [3:0]        s_mask,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_busy,
   output logic              grant,
   output logic              timeout_err
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   state_t                   state_q, state_d;
   logic [1:0]               re_in, we_in;
   logic [1:0][ADDR_W-1:0]   addr_in;
   logic [1:0][DATA_W-1:0]   wdata_in;
   logic [1:0][3:0]          mask_in;
   logic [1:0]               busy_q, busy_d, op_we_q, op_we_d;
   logic [1:0][ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0][DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0][3:0]          mask_q, mask_d;
   logic                     grant_q, grant_d, last_q, last_d, sel;
   logic                     s_re_q, s_re_d, s_we_q, s_we_d;
   logic [ADDR_W-1:0]        s_addr_q, s_addr_d;
   logic [DATA_W-1:0]        s_wdata_q, s_wdata_d;
   logic [3:0]               s_mask_q, s_mask_d;
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     tmo_q, tmo_d;
   assign timeout_err = tmo_q;
`else
   assign timeout_err = 1'b0;
`endif
   assign re_in    = {m1_re, m0_re};
   assign we_in    = {m1_we, m0_we};
   assign addr_in  = {m1_addr, m0_addr};
   assign wdata_in = {m1_wdata, m0_wdata};
   assign mask_in  = {m1_mask, m0_mask};
   assign m0_busy  = busy_q[0];
   assign m1_busy  = busy_q[1];
   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
   assign s_re     = s_re_q;
   assign s_we     = s_we_q;
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;
   assign s_mask   = s_mask_q;
   assign grant    = grant_q;
   // On a tie the master that did not win last time is served.
   assign sel = (busy_q == 2'b11) ? ~last_q : busy_q[1];
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      op_we_d   = op_we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      rdata_d   = rdata_q;
      grant_d   = grant_q;
      last_d    = last_q;
      s_re_d    = 1'b0;
      s_we_d    = 1'b0;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_mask_d  = s_mask_q;
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
      cnt_d     = cnt_q;
      tmo_d     = 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
         if (!busy_q[i] && (re_in[i] || we_in[i])) begin
            busy_d[i]  = 1'b1;
            op_we_d[i] = we_in[i];
            addr_d[i]  = addr_in[i];
            wdata_d[i] = wdata_in[i];
            mask_d[i]  = mask_in[i];
         end
      end
      case (state_q)
         S_IDLE: begin
            if (|busy_q) begin
               state_d   = S_ISSUE;
               grant_d   = sel;
               last_d    = sel;
               s_re_d    = ~op_we_q[sel];
               s_we_d    = op_we_q[sel];
               s_addr_d  = addr_q[sel];
               s_wdata_d = wdata_q[sel];
               s_mask_d  = mask_q[sel];
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (!s_busy) begin
               rdata_d[grant_q] = op_we_q[grant_q] ? rdata_q[grant_q] : s_rdata;
               busy_d[grant_q]  = 1'b0;
               state_d          = S_IDLE;
            end
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rdata_d[grant_q] = op_we_q[grant_q] ? rdata_q[grant_q] : '0;
               busy_d[grant_q]  = 1'b0;
               tmo_d            = 1'b1;
               state_d          = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         busy_q    <= '0;
         op_we_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         rdata_q   <= '0;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         s_re_q    <= 1'b0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_mask_q  <= '0;
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
         cnt_q     <= '0;
         tmo_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         op_we_q   <= op_we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         rdata_q   <= rdata_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         s_re_q    <= s_re_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_mask_q  <= s_mask_d;
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
`endif
      end
   end
endmodule

// File: tb/tb_zpu_mem_arbiter.sv
// tb_zpu_mem_arbiter: vector table plus hand sequences for the two-master arbiter.
module tb_zpu_mem_arbiter;
   typedef struct {
      logic [31:0] r0, w0, a0, d0, k0;
      logic [31:0] r1, w1, a1, d1, k1;
      logic [31:0] lat, srd;
      logic [31:0] en, eg, eop, ea, ed, ek, erd0, erd1;
   } vec_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic [27:0] m0_addr = '0, m1_addr = '0, s_addr;
   logic        m0_re = 1'b0, m0_we = 1'b0, m1_re = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, s_wdata;
   logic [3:0]  m0_mask = '0, m1_mask = '0, s_mask;
   logic        m0_busy, m1_busy, s_re, s_we, grant, timeout_err;
   logic [31:0] s_rdata = '0;
   logic        s_busy = 1'b0;

   int          tests = 0, fails = 0;
   int          lat_cfg = 0;
   logic [31:0] srd_cfg = '0;
   int          acc_n = 0, bcnt = 0, tmo_seen = 0;
   logic [1:0]  acc_op [64];
   logic        acc_g  [64];
   logic [27:0] acc_a  [64];
   logic [31:0] acc_d  [64];
   logic [3:0]  acc_k  [64];
   vec_t        vecs   [8];

   always #5 clk = ~clk;

   zpu_mem_arbiter #(.ADDR_W(28), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .m0_addr(m0_addr), .m0_re(m0_re), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
      .m0_rdata(m0_rdata), .m0_busy(m0_busy),
      .m1_addr(m1_addr), .m1_re(m1_re), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
      .m1_rdata(m1_rdata), .m1_busy(m1_busy),
      .s_addr(s_addr), .s_re(s_re), .s_we(s_we), .s_wdata(s_wdata), .s_mask(s_mask),
      .s_rdata(s_rdata), .s_busy(s_busy), .grant(grant), .timeout_err(timeout_err)
   );

   // Slave model: logs every strobe cycle, then holds busy for lat_cfg cycles.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s_busy <= 1'b0;
         bcnt   <= 0;
      end else if (s_re || s_we) begin
         if (acc_n < 64) begin
            acc_op[acc_n] <= {s_re, s_we};
            acc_g[acc_n]  <= grant;
            acc_a[acc_n]  <= s_addr;
            acc_d[acc_n]  <= s_wdata;
            acc_k[acc_n]  <= s_mask;
         end
         acc_n   <= acc_n + 1;
         bcnt    <= lat_cfg;
         s_busy  <= lat_cfg > 0;
         s_rdata <= srd_cfg;
      end else if (bcnt > 0) begin
         bcnt   <= bcnt - 1;
         s_busy <= bcnt > 1;
      end
   end

   always @(negedge clk) if (timeout_err) tmo_seen++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t one(input int m, input logic w, input logic [31:0] a, d, k);
      vec_t v = '{default: 'h0};
      if (m == 0) begin
         v.r0 = {31'h0, ~w}; v.w0 = {31'h0, w}; v.a0 = a; v.d0 = d; v.k0 = k;
      end else begin
         v.r1 = {31'h0, ~w}; v.w1 = {31'h0, w}; v.a1 = a; v.d1 = d; v.k1 = k;
      end
      return v;
   endfunction

   task automatic drive(input vec_t v);
      m0_re = v.r0[0]; m0_we = v.w0[0]; m0_addr = v.a0[27:0]; m0_wdata = v.d0; m0_mask = v.k0[3:0];
      m1_re = v.r1[0]; m1_we = v.w1[0]; m1_addr = v.a1[27:0]; m1_wdata = v.d1; m1_mask = v.k1[3:0];
      @(negedge clk);
      m0_re = 1'b0; m0_we = 1'b0; m1_re = 1'b0; m1_we = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output int cyc);
      cyc = 0;
      while ((m0_busy || m1_busy) && cyc < bound) begin
         cyc++;
         @(negedge clk);
      end
      if (m0_busy || m1_busy) begin
         tests++;
         fails++;
         $display("FAIL idle_wait: busy still 1 after %0d cycles, expected 0", bound);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, cyc, k, t0;
      vec_t h;
      vecs[0] = '{'h1,'h0,'h10,'h0,'h0, 'h0,'h0,'h0,'h0,'h0, 'h0,'h100,
                  'h1,'h0,'h2,'h10,'h0,'h0, 'h100,'h0};
      vecs[1] = '{'h0,'h0,'h0,'h0,'h0, 'h0,'h1,'h20,'hCAFEF00D,'h3, 'h4,'hDEAD,
                  'h1,'h1,'h1,'h20,'hCAFEF00D,'h3, 'h100,'h0};
      vecs[2] = '{'h1,'h0,'h30,'h0,'h0, 'h1,'h0,'h40,'h0,'h0, 'h1,'h55,
                  'h2,'h0,'h2,'h30,'h0,'h0, 'h55,'h55};
      vecs[3] = '{'h1,'h0,'h50,'h0,'h0, 'h1,'h0,'h60,'h0,'h0, 'h0,'h77,
                  'h2,'h0,'h2,'h50,'h0,'h0, 'h77,'h77};
      vecs[4] = '{'h1,'h1,'h4,'h12345678,'hF, 'h0,'h0,'h0,'h0,'h0, 'h0,'h99,
                  'h1,'h0,'h1,'h4,'h12345678,'hF, 'h77,'h77};
      vecs[5] = '{'h0,'h0,'h0,'h0,'h0, 'h1,'h0,'h70,'h0,'h0, 'h2,'hABCD,
                  'h1,'h1,'h2,'h70,'h0,'h0, 'h77,'hABCD};
      vecs[6] = '{'h0,'h1,'h80,'h11111111,'h1, 'h0,'h1,'h90,'h22222222,'h2, 'h0,'h5,
                  'h2,'h0,'h1,'h80,'h11111111,'h1, 'h77,'hABCD};
      vecs[7] = '{'h0,'h1,'hA0,'h33333333,'hC, 'h1,'h0,'hB0,'h0,'h0, 'h1,'h6,
                  'h2,'h0,'h1,'hA0,'h33333333,'hC, 'h77,'h6};

      repeat (3) @(negedge clk);
      chk("rst_m0_busy", 32'(m0_busy), 'h0);
      chk("rst_m1_busy", 32'(m1_busy), 'h0);
      chk("rst_s_re", 32'(s_re), 'h0);
      chk("rst_s_we", 32'(s_we), 'h0);
      chk("rst_grant", 32'(grant), 'h0);
      chk("rst_timeout_err", 32'(timeout_err), 'h0);
      chk("rst_m0_rdata", m0_rdata, 'h0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         base    = acc_n;
         lat_cfg = int'(vecs[i].lat);
         srd_cfg = vecs[i].srd;
         drive(vecs[i]);
         wait_idle(200, cyc);
         chk($sformatf("v%0d_accesses", i), 32'(acc_n - base), vecs[i].en);
         chk($sformatf("v%0d_grant", i), 32'(acc_g[base]), vecs[i].eg);
         chk($sformatf("v%0d_op", i), 32'(acc_op[base]), vecs[i].eop);
         chk($sformatf("v%0d_addr", i), 32'(acc_a[base]), vecs[i].ea);
         chk($sformatf("v%0d_wdata", i), acc_d[base], vecs[i].ed);
         chk($sformatf("v%0d_mask", i), 32'(acc_k[base]), vecs[i].ek);
         chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].erd0);
         chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].erd1);
         if (vecs[i].en == 'h2) chk($sformatf("v%0d_grant2", i), 32'(acc_g[base + 1]), {31'h0, ~vecs[i].eg[0]});
      end

      // Busy window: 3 cycles zero-wait, 3 + 4 with a 4-cycle busy slave.
      lat_cfg = 0; srd_cfg = 'h100;
      drive(one(0, 1'b0, 'h10, 'h0, 'h0));
      wait_idle(200, cyc);
      chk("m0_busy_window", 32'(cyc), 'h3);
      lat_cfg = 4;
      drive(one(1, 1'b1, 'h20, 'hCAFEF00D, 'h3));
      wait_idle(200, cyc);
      chk("m1_busy_window", 32'(cyc), 'h7);

      // A second strobe while busy must be ignored.
      base = acc_n; lat_cfg = 0; srd_cfg = 'h4242;
      m0_addr = 'h100; m0_re = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m0_re = 1'b0;
      wait_idle(200, cyc);
      repeat (5) @(negedge clk);
      chk("busy_strobe_ignored", 32'(acc_n - base), 'h1);
      chk("busy_strobe_rdata", m0_rdata, 'h4242);

      // Slave stuck busy on an m0 read.
      lat_cfg = 1000; srd_cfg = 'h1234; t0 = tmo_seen;
      drive(one(0, 1'b0, 'h200, 'h0, 'h0));
`ifdef ZPU_MEM_ARBITER_TIMEOUT_EN
      wait_idle(60, cyc);
      repeat (2) @(negedge clk);
      chk("tmo_busy_window", 32'(cyc), 'd18);
      chk("tmo_pulses", 32'(tmo_seen - t0), 'h1);
      chk("tmo_m0_rdata", m0_rdata, 'h0);
`else
      repeat (40) @(negedge clk);
      chk("notmo_m0_busy", 32'(m0_busy), 'h1);
      chk("notmo_pulses", 32'(tmo_seen - t0), 'h0);
`endif
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Asynchronous reset during WAIT of an m1 read.
      lat_cfg = 20; srd_cfg = 'h5;
      drive(one(1, 1'b0, 'h300, 'h0, 'h0));
      k = 0;
      while (!s_busy && k < 10) begin
         k++;
         @(negedge clk);
      end
      chk("ar_in_wait", 32'(s_busy), 'h1);
      chk("ar_grant_before", 32'(grant), 'h1);
      chk("ar_m1_busy_before", 32'(m1_busy), 'h1);
      #2 reset = 1'b1;
      #1;
      chk("ar_s_re", 32'(s_re), 'h0);
      chk("ar_s_we", 32'(s_we), 'h0);
      chk("ar_m0_busy", 32'(m0_busy), 'h0);
      chk("ar_m1_busy", 32'(m1_busy), 'h0);
      chk("ar_grant", 32'(grant), 'h0);
      @(negedge clk);
      reset = 1'b0;
      base = acc_n;
      repeat (10) @(negedge clk);
      chk("ar_no_replay", 32'(acc_n - base), 'h0);
      chk("ar_m1_busy_after", 32'(m1_busy), 'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/zpu_mem_arbiter.md
Name: zpu_mem_arbiter

Overview:
Two-master, one-slave memory-bus arbiter for the zpu_core memory interface (strobe plus busy protocol, 28-bit word address, 32-bit data, 4-bit write mask).
- Master 0 is the ZPU core; master 1 is an auxiliary requester (DMA or debug loader).
- Each master request is latched, the two masters are arbitrated round-robin, and each transaction is replayed to the single memory/IO slave as a one-cycle strobe.
- Each master's busy and read data are returned using the same protocol the core expects.

Parameters:
ADDR_W, 28, address width (matches out_mem_addr)
DATA_W, 32, data width
TIMEOUT_CYCLES, 1024, slave-busy watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
m0_addr  in  ADDR_W  master 0 address
m0_re  in  1  master 0 read strobe
m0_we  in  1  master 0 write strobe
m0_wdata  in  DATA_W  master 0 write data
m0_mask  in  4  master 0 byte write mask
m0_rdata  out  DATA_W  master 0 read data (registered)
m0_busy  out  1  master 0 busy (registered)
m1_addr, m1_re, m1_we, m1_wdata, m1_mask, m1_rdata, m1_busy  as m0, for master 1
s_addr  out  ADDR_W  slave address
s_re  out  1  slave read strobe
s_we  out  1  slave write strobe
s_wdata  out  DATA_W  slave write data
s_mask  out  4  slave write mask
s_rdata  in  DATA_W  slave read data
s_busy  in  1  slave busy
grant  out  1  index of master owning the slave; valid while not IDLE
timeout_err  out  1  one-cycle watchdog abort pulse

Behaviour:
Reset values (all outputs driven 0 asynchronously while reset is high):
- s_re, s_we, m*_busy, m*_rdata, s_addr, s_wdata, s_mask, grant, timeout_err all 0.
- State = IDLE; both pending flags = 0; last_grant = 1, so master 0 wins the first tie.

Capture:
- A strobe (m*_re or m*_we) sampled while that master's busy = 0 sets the master's pending flag and latches addr, wdata, mask and op.
- m*_busy goes to 1 at the same edge.
- If re and we are both high, the request is a write.
- Strobes arriving while that master's busy = 1 are ignored.

FSM:
- IDLE
  - No pending: stay in IDLE.
  - One master pending: grant it.
  - Both pending: grant the master that is not last_grant.
  - On a grant, go to ISSUE; update grant and last_grant.
- ISSUE
  - For exactly one cycle, drive s_re or s_we with the latched addr, wdata and mask.
  - Go to WAIT.
- WAIT
  - s_addr, s_wdata and s_mask stay held.
  - At the first edge where s_busy = 0:
    - for a read, register s_rdata into m[grant]_rdata;
    - clear pending and m[grant]_busy;
    - go to IDLE.
  - s_busy = 1: remain in WAIT.

Timing:
- Minimum busy window for an uncontended request is 3 cycles (capture, ISSUE, WAIT with zero-wait slave).
- m*_rdata is valid from the edge where busy falls and holds until that master's next read completes.
- A request captured during another master's transaction waits; it is issued after the current transaction returns to IDLE.
- Writes leave m*_rdata unchanged.
- reset asserted mid-transaction aborts it; pending requests are discarded and not replayed.

Optional Feature:
Macro ZPU_MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle with s_busy = 1.
  - On reaching TIMEOUT_CYCLES, the transaction is aborted: m[grant]_rdata = 0 for a read, pending and busy are cleared, timeout_err pulses for 1 cycle, and state goes to IDLE.
- Not defined: no counter is built, timeout_err is tied 0, and WAIT lasts indefinitely.

Test Plan:
1. m0 read at addr 0x0000010, slave zero-wait with s_rdata = 32'h00000100 -> exactly one s_re cycle with s_addr = 0x0000010; m0_busy high 3 cycles; m0_rdata = 0x100.
2. m1 write of 0xCAFEF00D with mask 4'b0011, slave holds s_busy for 4 cycles -> single s_we pulse with those data and mask; grant = 1; m1_busy falls at the first edge with s_busy = 0; m1_rdata unchanged.
3. m0 and m1 read strobes in the same cycle after reset -> m0 is served first and m1 second (two s_re pulses, grant 0 then 1). A repeated simultaneous pair is served m0 then m1 again.
4. m0 asserts re and we together (addr 0x4, data 0x12345678) -> s_we pulses and s_re never asserts. A second m0 strobe while m0_busy = 1 produces no extra slave access.
5. reset raised during WAIT of an m1 read -> s_re, s_we, both busy outputs and grant go to 0 immediately (asynchronously). After release there is no slave strobe without a new request.
6. Macro defined, TIMEOUT_CYCLES = 16, s_busy stuck at 1 on an m0 read -> 16 WAIT cycles then a timeout_err pulse, m0_busy falls, m0_rdata = 0. With the macro undefined, m0_busy stays high and timeout_err stays 0.
